// File: rtl/mcs4_rom_bank.sv
// MCS-4 ROM bank: emulates NUM_ROMS 4001-style 256-byte ROM chips with 4-bit I/O ports,
// sharing the 4-bit multiplexed CPU data bus, plus a side-band debug read/write port.
module mcs4_rom_bank #(
    parameter int unsigned              NUM_ROMS       = 4,
    parameter logic [3:0]               ROM_BASE_ID    = 4'h0,
    parameter logic [NUM_ROMS-1:0][3:0] IO_MASK        = '1,
    parameter int unsigned              IO_SYNC_STAGES = 2,
    parameter string                    ROM_FILE       = ""
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sync,
    input  logic                       cl_rom,
    input  logic                       cm_rom,
    input  logic [3:0]                 dbus_in,
    output logic [3:0]                 dbus_out,
    input  logic [NUM_ROMS-1:0][3:0]   io_in,
    output logic [NUM_ROMS-1:0][3:0]   io_out,
    input  logic [2:0][3:0]            dbg_addr,
    input  logic [7:0]                 dbg_wdata,
    input  logic                       dbg_wen,
    output logic [7:0]                 dbg_rdata
);

    typedef logic [3:0] char_t;
    typedef logic [7:0] byte_t;

    // I/O opcodes as they appear in OPA after the 4'hE OPR prefix
    localparam char_t OpWrr = 4'h2;
    localparam char_t OpRdr = 4'hA;

    localparam int unsigned AW       = $clog2(NUM_ROMS * 256);
    localparam logic [4:0]  NumRomsW = 5'(NUM_ROMS);

    typedef enum logic [2:0] {
        PhA1, PhA2, PhA3, PhM1, PhM2, PhX1, PhX2, PhX3
    } phase_e;

    phase_e phase_q, phase_d;
    char_t  addr_lo_q, addr_lo_d;
    char_t  addr_mid_q, addr_mid_d;
    char_t  chip_id_q, chip_id_d;
    char_t  opa_q;
    logic   opa_valid_q;
    char_t  chip_sel_q;

    logic [NUM_ROMS-1:0][3:0] io_out_q, io_out_d;
    logic [NUM_ROMS-1:0][3:0] io_in_s;

    byte_t mem [NUM_ROMS*256];
    byte_t rom_q;
    byte_t dbg_rdata_q;

    // Offset of a chip ID from the bank base; bit 4 set (borrow) means below the base
    function automatic logic [4:0] id_offset(input logic [3:0] id);
        return {1'b0, id} - {1'b0, ROM_BASE_ID};
    endfunction

    logic [4:0]    id_off_q, id_off_d, cs_off, dbg_off;
    logic          id_hit_q, id_hit_d, cs_hit, dbg_hit;
    logic [3:0]    cs_k;
    logic [AW-1:0] rd_idx, dbg_idx;
    logic          io_exec;

    assign id_off_q = id_offset(chip_id_q);
    assign id_off_d = id_offset(chip_id_d);
    assign cs_off   = id_offset(chip_sel_q);
    assign dbg_off  = id_offset(dbg_addr[2]);
    assign id_hit_q = id_off_q < NumRomsW;
    assign id_hit_d = id_off_d < NumRomsW;
    assign cs_hit   = cs_off < NumRomsW;
    assign dbg_hit  = dbg_off < NumRomsW;
    assign cs_k     = cs_off[3:0];
    assign rd_idx   = AW'({id_off_d[3:0], addr_mid_d, addr_lo_d});
    assign dbg_idx  = AW'({dbg_off[3:0], dbg_addr[1], dbg_addr[0]});
    assign io_exec  = (phase_q == PhX2) && opa_valid_q && cs_hit;

    // Next phase and address latches; sync restarts the cycle and drops any partial address
    always_comb begin
        phase_d    = phase_q;
        addr_lo_d  = addr_lo_q;
        addr_mid_d = addr_mid_q;
        chip_id_d  = chip_id_q;
        if (sync) begin
            phase_d    = PhA1;
            addr_lo_d  = '0;
            addr_mid_d = '0;
            chip_id_d  = '0;
        end else begin
            if (phase_q != PhX3) begin
                phase_d = phase_e'(phase_q + 3'd1);
            end
            case (phase_q)
                PhA1:    addr_lo_d  = dbus_in;
                PhA2:    addr_mid_d = dbus_in;
                PhA3:    chip_id_d  = dbus_in;
                default: ;
            endcase
        end
    end

    // Bus cycle state: phase, address, opcode and SRC chip select
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= PhX3;
            addr_lo_q   <= '0;
            addr_mid_q  <= '0;
            chip_id_q   <= '0;
            opa_q       <= OpWrr;
            opa_valid_q <= 1'b0;
            chip_sel_q  <= '0;
        end else begin
            phase_q    <= phase_d;
            addr_lo_q  <= addr_lo_d;
            addr_mid_q <= addr_mid_d;
            chip_id_q  <= chip_id_d;
            if (phase_q == PhM2) begin
                opa_q       <= dbus_in;
                opa_valid_q <= cm_rom;
            end
            if (phase_q == PhX2 && cm_rom) begin
                chip_sel_q <= dbus_in;
            end
        end
    end

    // ROM array: debug write plus bus read; reading the d-side address makes data ready at M1
    always_ff @(posedge clk) begin
        if (dbg_wen && dbg_hit) begin
            mem[dbg_idx] <= dbg_wdata;
        end
        rom_q <= id_hit_d ? mem[rd_idx] : '0;
    end

    // Registered debug read
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_rdata_q <= '0;
        end else begin
            dbg_rdata_q <= dbg_hit ? mem[dbg_idx] : '0;
        end
    end

    assign dbg_rdata = dbg_rdata_q;

    if (IO_SYNC_STAGES == 0) begin : g_sync0
        assign io_in_s = io_in;
    end else if (IO_SYNC_STAGES == 1) begin : g_sync1
        logic [NUM_ROMS-1:0][3:0] s1_q;
        // Single-stage input register
        always_ff @(posedge clk) begin
            if (rst) s1_q <= '0;
            else     s1_q <= io_in;
        end
        assign io_in_s = s1_q;
    end else begin : g_sync2
        logic [NUM_ROMS-1:0][3:0] s1_q, s2_q;
        // Two-flop synchroniser for asynchronous pin inputs
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q <= '0;
                s2_q <= '0;
            end else begin
                s1_q <= io_in;
                s2_q <= s1_q;
            end
        end
        assign io_in_s = s2_q;
    end

    // Output latch update: cl_rom clears everything and overrides a WRR in the same cycle
    always_comb begin
        io_out_d = io_out_q;
        if (cl_rom) begin
            io_out_d = '0;
        end else if (io_exec && opa_q == OpWrr) begin
            for (int unsigned i = 0; i < NUM_ROMS; i++) begin
                if (cs_k == 4'(i)) io_out_d[i] = ~IO_MASK[i] & dbus_in;
            end
        end
    end

    // I/O output latches
    always_ff @(posedge clk) begin
        if (rst) io_out_q <= '0;
        else     io_out_q <= io_out_d;
    end

    assign io_out = io_out_q;

    // Bus drive: ROM nibbles at M1/M2, RDR port value at X2, zero otherwise
    always_comb begin
        dbus_out = '0;
        case (phase_q)
            PhM1: if (id_hit_q) dbus_out = rom_q[7:4];
            PhM2: if (id_hit_q) dbus_out = rom_q[3:0];
            PhX2: begin
                if (io_exec && opa_q == OpRdr) begin
                    for (int unsigned i = 0; i < NUM_ROMS; i++) begin
                        if (cs_k == 4'(i)) begin
                            dbus_out = (IO_MASK[i] & io_in_s[i]) | (~IO_MASK[i] & io_out_q[i]);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mcs4_rom_bank.sv
// Scoreboard bench for mcs4_rom_bank: stimulus queues expectations, a negedge monitor checks them.
module tb_mcs4_rom_bank;

    localparam int KBus = 0;
    localparam int KIo  = 1;
    localparam int KDbg = 2;

    logic            clk = 1'b0;
    logic            rst, sync, cl_rom, cm_rom, dbg_wen;
    logic [3:0]      dbus_in, dbus_out;
    logic [3:0][3:0] io_in, io_out;
    logic [2:0][3:0] dbg_addr;
    logic [7:0]      dbg_wdata, dbg_rdata;
    logic            a3_dbg;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          due;
        int          kind;
        logic [15:0] exp;
        string       name;
    } chk_t;

    chk_t sbq[$];

    mcs4_rom_bank #(
        .NUM_ROMS       (4),
        .ROM_BASE_ID    (4'h2),
        .IO_MASK        (16'hFF3F),
        .IO_SYNC_STAGES (2),
        .ROM_FILE       ("")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sync      (sync),
        .cl_rom    (cl_rom),
        .cm_rom    (cm_rom),
        .dbus_in   (dbus_in),
        .dbus_out  (dbus_out),
        .io_in     (io_in),
        .io_out    (io_out),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_wen   (dbg_wen),
        .dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation due this cycle and compare against the DUT
    always @(negedge clk) begin
        chk_t        c;
        logic [15:0] act;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            c = sbq.pop_front();
            case (c.kind)
                KBus:    act = {12'h000, dbus_out};
                KIo:     act = io_out;
                default: act = {8'h00, dbg_rdata};
            endcase
            n_checks++;
            if (c.due != cyc || act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                         c.name, act, c.exp, cyc, c.due);
            end
        end
    end

    task automatic expect_at(input string nm, input int kind, input logic [15:0] exp,
                             input int due);
        chk_t c;
        c.due  = due;
        c.kind = kind;
        c.exp  = exp;
        c.name = nm;
        sbq.push_back(c);
    endtask

    task automatic drive(input logic s, input logic [3:0] d, input logic cm);
        sync    = s;
        dbus_in = d;
        cm_rom  = cm;
        @(posedge clk);
        #1;
    endtask

    // One full instruction cycle: sync, A1..A3, M1, M2, X1, X2, X3
    task automatic instr(input string nm, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [3:0] a3, input logic [3:0] m2d, input logic m2cm,
                         input logic [3:0] x2d, input logic x2cm, input logic x2cl,
                         input logic [3:0] em1, input logic [3:0] em2, input logic [3:0] ex2);
        drive(1'b1, 4'h0, 1'b0);
        expect_at({nm, "_a1"}, KBus, 16'h0, cyc);
        drive(1'b0, a1, 1'b0);
        drive(1'b0, a2, 1'b0);
        dbg_wen = a3_dbg;
        drive(1'b0, a3, 1'b0);
        dbg_wen = 1'b0;
        expect_at({nm, "_m1"}, KBus, {12'h0, em1}, cyc);
        drive(1'b0, 4'h0, 1'b0);
        expect_at({nm, "_m2"}, KBus, {12'h0, em2}, cyc);
        drive(1'b0, m2d, m2cm);
        drive(1'b0, 4'h0, 1'b0);
        expect_at({nm, "_x2"}, KBus, {12'h0, ex2}, cyc);
        cl_rom = x2cl;
        drive(1'b0, x2d, x2cm);
        cl_rom = 1'b0;
        expect_at({nm, "_x3"}, KBus, 16'h0, cyc);
        drive(1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; cl_rom = 1'b0; cm_rom = 1'b0; dbus_in = '0;
        io_in = '0; dbg_addr = '0; dbg_wdata = '0; dbg_wen = 1'b0; a3_dbg = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        expect_at("rst_dbus", KBus, 16'h0, cyc);
        expect_at("rst_io",   KIo,  16'h0, cyc);
        expect_at("rst_dbg",  KDbg, 16'h0, cyc);
        drive(1'b0, 4'h0, 1'b0);
        rst = 1'b0;

        // Debug load chip 3 byte 0x5A = 0xC7, then read it back
        dbg_addr = {4'h3, 4'h5, 4'hA}; dbg_wdata = 8'hC7; dbg_wen = 1'b1;
        drive(1'b0, 4'h0, 1'b0);
        dbg_wen = 1'b0;
        expect_at("dbg_rd_c7", KDbg, 16'h00C7, cyc + 1);
        drive(1'b0, 4'h0, 1'b0);
        drive(1'b0, 4'h0, 1'b0);

        instr("fetch_c3", 4'hA, 4'h5, 4'h3, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'hC, 4'h7, 4'h0);
        instr("fetch_id6", 4'hA, 4'h5, 4'h6, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);

        // Debug write of the byte being fetched at A3: M1 sees old data, M2 the new byte
        dbg_wdata = 8'h3E; a3_dbg = 1'b1;
        instr("fetch_wr", 4'hA, 4'h5, 4'h3, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'hC, 4'hE, 4'h0);
        a3_dbg = 1'b0;

        // SRC chip 3, WRR F -> io_out[1] = 1100
        instr("src3", 4'h0, 4'h0, 4'h6, 4'h0, 1'b0, 4'h3, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        instr("wrr_f", 4'h0, 4'h0, 4'h6, 4'h2, 1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        expect_at("io_wrr", KIo, 16'h00C0, cyc);
        n_checks++;
        if (io_out !== 16'h00C0) begin
            n_fail++;
            $display("FAIL io_wrr_direct: got %h expected 00c0", io_out);
        end

        // RDR with io_in[1] = 0101 -> 1101
        io_in = 16'h0050;
        instr("rdr", 4'h0, 4'h0, 4'h6, 4'hA, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'hD);
        expect_at("io_rdr", KIo, 16'h00C0, cyc);

        // WRR with cl_rom in the same X2 -> all clear
        instr("wrr_cl", 4'h0, 4'h0, 4'h6, 4'h2, 1'b1, 4'hF, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        expect_at("io_cl", KIo, 16'h0, cyc);
        n_checks++;
        if (io_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL io_cl_direct: got %h expected 0000", io_out);
        end

        // RDR without cm_rom at M2 drives nothing
        instr("rdr_nov", 4'h0, 4'h0, 4'h6, 4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);

        // Out-of-range chip select leaves io_out alone and reads 0
        instr("wrr_f2", 4'h0, 4'h0, 4'h6, 4'h2, 1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        expect_at("io_wrr2", KIo, 16'h00C0, cyc);
        instr("src7", 4'h0, 4'h0, 4'h6, 4'h0, 1'b0, 4'h7, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        instr("wrr_oor", 4'h0, 4'h0, 4'h6, 4'h2, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        expect_at("io_oor", KIo, 16'h00C0, cyc);
        instr("rdr_oor", 4'h0, 4'h0, 4'h6, 4'hA, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);

        // Reset asserted at M1: bus stays quiet, io_out cleared
        drive(1'b1, 4'h0, 1'b0);
        drive(1'b0, 4'hA, 1'b0);
        drive(1'b0, 4'h5, 1'b0);
        drive(1'b0, 4'h3, 1'b0);
        rst = 1'b1;
        drive(1'b0, 4'h0, 1'b0);
        rst = 1'b0;
        expect_at("io_rst_m1", KIo, 16'h0, cyc);
        for (int i = 0; i < 7; i++) begin
            expect_at("rst_m1_quiet", KBus, 16'h0, cyc);
            drive(1'b0, 4'hF, 1'b1);
        end

        // Aborted address (sync mid-cycle) followed by a clean fetch
        drive(1'b1, 4'h0, 1'b0);
        drive(1'b0, 4'h1, 1'b0);
        drive(1'b0, 4'h2, 1'b0);
        instr("fetch_rst", 4'hA, 4'h5, 4'h3, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h3, 4'hE, 4'h0);

        // No sync for 20 cycles: bus stays 0 whatever dbus_in/cm_rom do
        for (int i = 0; i < 20; i++) begin
            expect_at("idle_quiet", KBus, 16'h0, cyc);
            drive(1'b0, 4'(i), 1'(i));
        end

        // Debug write chip 2 byte 0x00 and read back
        dbg_addr = {4'h2, 4'h0, 4'h0}; dbg_wdata = 8'h96; dbg_wen = 1'b1;
        drive(1'b0, 4'h0, 1'b0);
        dbg_wen = 1'b0;
        expect_at("dbg_c2_b0", KDbg, 16'h0096, cyc + 1);
        drive(1'b0, 4'h0, 1'b0);
        drive(1'b0, 4'h0, 1'b0);
        n_checks++;
        if (dbg_rdata !== 8'h96) begin
            n_fail++;
            $display("FAIL dbg_c2_direct: got %h expected 96", dbg_rdata);
        end

        // Out-of-range debug write must not alias onto chip 2
        dbg_addr = {4'h6, 4'h0, 4'h0}; dbg_wdata = 8'h11; dbg_wen = 1'b1;
        drive(1'b0, 4'h0, 1'b0);
        dbg_wen = 1'b0;
        dbg_addr = {4'h2, 4'h0, 4'h0};
        expect_at("dbg_oor", KDbg, 16'h0096, cyc + 1);
        drive(1'b0, 4'h0, 1'b0);
        drive(1'b0, 4'h0, 1'b0);
        n_checks++;
        if (dbg_rdata !== 8'h96) begin
            n_fail++;
            $display("FAIL dbg_oor_direct: got %h expected 96", dbg_rdata);
        end

        instr("fetch_c2", 4'h0, 4'h0, 4'h2, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h9, 4'h6, 4'h0);

        for (int i = 0; i < 20 && sbq.size() > 0; i++) drive(1'b0, 4'h0, 1'b0);
        while (sbq.size() > 0) begin
            chk_t c;
            c = sbq.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never compared, expected %h (due %0d)", c.name, c.exp, c.due);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
